// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: the only Avalon-MM master of the multicycle CPU.
// It arbitrates between instruction fetch and the load/store path, runs one
// bus transaction at a time, and absorbs waitrequest stalls. It also
// generates byte enables, rejects misaligned accesses, replicates store data
// across byte lanes and extends load data, so the CPU FSM only has to issue a
// request and wait for its ack.
//
// Ports:
//   clk, reset_i           clock; synchronous active-low reset
//   fetch_*                fetch requester: req/addr in, ack/data out
//   data_*                 load/store requester: req/we/size/signed/addr/wdata
//                          in, ack/rdata out
//   misalign_o             pulses with the ack of a rejected misaligned access
//   busy_o                 high whenever the FSM is not in IDLE
//   address_o .. readdata_i  Avalon-MM master interface

// One byte lane of the store path. Produces this lane's byte enable and its
// write byte from the access size and the address offset.
module mem_bus_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wd
);
  localparam logic [1:0] L = LANE[1:0];

  always_comb begin
    be = 1'b1;
    wd = wdata[8*LANE +: 8];
    case (size)
      2'b00: begin
        be = (off == L);
        wd = wdata[7:0];
      end
      2'b01: begin
        be = (off[1] == L[1]);
        wd = wdata[8*(LANE%2) +: 8];
      end
      default: ;
    endcase
  end
endmodule

module mem_bus_ctrl #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_ack_o,
  output logic [31:0] fetch_data_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [1:0]  data_size_i,
  input  logic        data_signed_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_ack_o,
  output logic [31:0] data_rdata_o,
  output logic        misalign_o,
  output logic        busy_o,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  input  logic        waitrequest_i,
  output logic [31:0] writedata_o,
  output logic [3:0]  byteenable_o,
  input  logic [31:0] readdata_i
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  typedef struct packed {
    logic        is_data;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q, req_nxt;
  logic        mis_q, mis_nxt;
  logic [31:0] rdata_q;
  logic        pick_data;

  // Grant and alignment check for whatever is pending in IDLE. A fetch is
  // latched as an unsigned word read so the rest of the datapath treats it
  // exactly like LW.
  always_comb begin
    pick_data = data_req_i && (!fetch_req_i || DATA_FIRST);
    if (pick_data)
      req_nxt = '{is_data: 1'b1, we: data_we_i, size: data_size_i,
                  sgn: data_signed_i, addr: data_addr_i, wdata: data_wdata_i};
    else
      req_nxt = '{is_data: 1'b0, we: 1'b0, size: 2'b10, sgn: 1'b0,
                  addr: fetch_addr_i, wdata: 32'h0};
    case (req_nxt.size)
      2'b00:   mis_nxt = 1'b0;
      2'b01:   mis_nxt = req_nxt.addr[0];
      default: mis_nxt = |req_nxt.addr[1:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_req_i || data_req_i) state_nxt = mis_nxt ? RESP : BUS;
      BUS:     if (!waitrequest_i) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      state   <= IDLE;
      req_q   <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (fetch_req_i || data_req_i)) begin
        req_q <= req_nxt;
        mis_q <= mis_nxt;
      end
      if (state == BUS && !waitrequest_i) rdata_q <= readdata_i;
    end
  end

  // Store-side byte lanes.
  logic [NUM_LANES-1:0]      be_lane;
  logic [NUM_LANES-1:0][7:0] wd_lane;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_bus_lane #(.LANE(g)) u_lane (
      .size  (req_q.size),
      .off   (req_q.addr[1:0]),
      .wdata (req_q.wdata),
      .be    (be_lane[g]),
      .wd    (wd_lane[g])
    );
  end

  // Load-side lane select and extension from the captured read word.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = rdata_q[8*req_q.addr[1:0] +: 8];
    ld_half = req_q.addr[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (req_q.size)
      2'b00:   ld_ext = {{24{req_q.sgn & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{req_q.sgn & ld_half[15]}}, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  // Everything below is decoded from state, so it reads 0 straight after reset.
  logic in_bus, in_resp, ok_resp;
  assign in_bus  = (state == BUS);
  assign in_resp = (state == RESP);
  assign ok_resp = in_resp && !mis_q;

  assign busy_o       = (state != IDLE);
  assign read_o       = in_bus && !req_q.we;
  assign write_o      = in_bus && req_q.we;
  assign address_o    = in_bus ? {req_q.addr[31:2], 2'b00} : 32'h0;
  assign byteenable_o = in_bus ? be_lane : 4'h0;
  assign writedata_o  = in_bus ? wd_lane : 32'h0;

  assign fetch_ack_o  = in_resp && !req_q.is_data;
  assign data_ack_o   = in_resp && req_q.is_data;
  assign misalign_o   = in_resp && mis_q;
  assign fetch_data_o = (ok_resp && !req_q.is_data) ? rdata_q : 32'h0;
  // Stores return 0; only loads carry extended read data.
  assign data_rdata_o = (ok_resp && req_q.is_data && !req_q.we) ? ld_ext : 32'h0;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;
  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        fetch_req_i = 1'b0;
  logic [31:0] fetch_addr_i = '0;
  logic        fetch_ack_o;
  logic [31:0] fetch_data_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [1:0]  data_size_i = '0;
  logic        data_signed_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_ack_o;
  logic [31:0] data_rdata_o;
  logic        misalign_o, busy_o;
  logic [31:0] address_o;
  logic        read_o, write_o;
  logic        waitrequest_i = 1'b0;
  logic [31:0] writedata_o;
  logic [3:0]  byteenable_o;
  logic [31:0] readdata_i = '0;

  mem_bus_ctrl #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .reset_i(reset_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_ack_o(fetch_ack_o), .fetch_data_o(fetch_data_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_size_i(data_size_i),
    .data_signed_i(data_signed_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_ack_o(data_ack_o),
    .data_rdata_o(data_rdata_o), .misalign_o(misalign_o), .busy_o(busy_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .waitrequest_i(waitrequest_i), .writedata_o(writedata_o),
    .byteenable_o(byteenable_o), .readdata_i(readdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit dat; bit we; bit [1:0] sz; bit sg;
    logic [31:0] addr, wdata, rd; int w; bit mis;
    logic [31:0] exp_addr; logic [3:0] exp_be; logic [31:0] exp_wd, exp_data;
  } vec_t;
  typedef struct { bit dat; logic [31:0] data; bit mis; int cyc; } resp_t;
  typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } bus_t;

  resp_t rq[$];
  bus_t  bq[$];
  int nchk = 0, nerr = 0;
  int cyc = 0;
  int wait_cfg = 0;
  int bus_cyc = 0;
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave model: stall the first wait_cfg cycles of each bus transaction.
  always @(posedge clk) begin
    #1;
    if (read_o || write_o) begin
      bus_cyc++;
      waitrequest_i = (bus_cyc <= wait_cfg);
    end else begin
      bus_cyc = 0;
      waitrequest_i = 1'b0;
    end
  end

  // Bus monitor: every BUS cycle must match the head transaction; it is
  // popped in the cycle the slave accepts it.
  always @(negedge clk) begin
    if (read_o || write_o) begin
      if (bq.size() == 0) chk("unexpected_bus", {30'h0, write_o, read_o}, 32'h0);
      else begin
        chk("bus_write", {31'h0, write_o}, {31'h0, bq[0].we});
        chk("bus_read", {31'h0, read_o}, {31'h0, !bq[0].we});
        chk("bus_addr", address_o, bq[0].addr);
        chk("bus_be", {28'h0, byteenable_o}, {28'h0, bq[0].be});
        if (bq[0].we) chk("bus_wdata", writedata_o, bq[0].wd);
        if (!waitrequest_i) void'(bq.pop_front());
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (fetch_ack_o || data_ack_o) begin
      if (rq.size() == 0) chk("unexpected_ack", {30'h0, data_ack_o, fetch_ack_o}, 32'h0);
      else begin
        resp_t e;
        e = rq.pop_front();
        chk("ack_kind", {30'h0, data_ack_o, fetch_ack_o}, e.dat ? 32'h2 : 32'h1);
        chk("ack_data", e.dat ? data_rdata_o : fetch_data_o, e.data);
        chk("ack_misalign", {31'h0, misalign_o}, {31'h0, e.mis});
        chk("ack_cycle", cyc, e.cyc);
      end
    end else if (misalign_o) chk("stray_misalign", 32'h1, 32'h0);
  end

  task automatic wait_ack(input bit for_data, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(for_data ? data_ack_o : fetch_ack_o) && n < 60);
    if (n >= 60) chk({nm, "_timeout"}, 32'h1, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    readdata_i = v.rd;
    wait_cfg = v.w;
    if (v.dat) begin
      data_req_i = 1'b1; data_we_i = v.we; data_size_i = v.sz;
      data_signed_i = v.sg; data_addr_i = v.addr; data_wdata_i = v.wdata;
    end else begin
      fetch_req_i = 1'b1; fetch_addr_i = v.addr;
    end
    rq.push_back('{dat: v.dat, data: v.exp_data, mis: v.mis,
                   cyc: cyc + (v.mis ? 1 : 2 + v.w)});
    if (!v.mis) bq.push_back('{we: v.we, addr: v.exp_addr, be: v.exp_be, wd: v.exp_wd});
    wait_ack(v.dat, $sformatf("vec%0d", idx));
    data_req_i = 1'b0;
    fetch_req_i = 1'b0;
  endtask

  initial begin
    //         dat we  sz    sg addr          wdata         rd            w  mis exp_addr      be    wd            data
    vecs[0]  = '{0, 0, 2'd2, 0, 32'hBFC00000, 32'h0,        32'h8C020004, 0, 0, 32'hBFC00000, 4'hF, 32'h0,        32'h8C020004};
    vecs[1]  = '{1, 0, 2'd0, 1, 32'h00001003, 32'h0,        32'h80FF7F01, 3, 0, 32'h00001000, 4'h8, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1, 0, 2'd0, 0, 32'h00001003, 32'h0,        32'h80FF7F01, 0, 0, 32'h00001000, 4'h8, 32'h0,        32'h00000080};
    vecs[3]  = '{1, 0, 2'd1, 0, 32'h00001002, 32'h0,        32'h80FF7F01, 0, 0, 32'h00001000, 4'hC, 32'h0,        32'h000080FF};
    vecs[4]  = '{1, 1, 2'd1, 0, 32'h00002002, 32'h1234ABCD, 32'hDEADBEEF, 0, 0, 32'h00002000, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[5]  = '{1, 0, 2'd2, 0, 32'h00002001, 32'h0,        32'hDEADBEEF, 0, 1, 32'h0,        4'h0, 32'h0,        32'h0};
    vecs[6]  = '{1, 0, 2'd1, 1, 32'h00001000, 32'h0,        32'h1234F00D, 0, 0, 32'h00001000, 4'h3, 32'h0,        32'hFFFFF00D};
    vecs[7]  = '{1, 0, 2'd0, 1, 32'h00001001, 32'h0,        32'h80FF7F01, 1, 0, 32'h00001000, 4'h2, 32'h0,        32'h0000007F};
    vecs[8]  = '{1, 1, 2'd0, 0, 32'h00003001, 32'h123456A5, 32'h0,        0, 0, 32'h00003000, 4'h2, 32'hA5A5A5A5, 32'h0};
    vecs[9]  = '{1, 1, 2'd3, 0, 32'h00003004, 32'hCAFEF00D, 32'h0,        2, 0, 32'h00003004, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[10] = '{0, 0, 2'd2, 0, 32'h00000102, 32'h0,        32'h55555555, 0, 1, 32'h0,        4'h0, 32'h0,        32'h0};
    vecs[11] = '{1, 0, 2'd1, 1, 32'h00001003, 32'h0,        32'h55555555, 0, 1, 32'h0,        4'h0, 32'h0,        32'h0};
    vecs[12] = '{1, 0, 2'd1, 1, 32'h00001002, 32'h0,        32'h80FF7F01, 0, 0, 32'h00001000, 4'hC, 32'h0,        32'hFFFF80FF};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_rw", {30'h0, read_o, write_o}, 32'h0);
    chk("rst_acks", {29'h0, fetch_ack_o, data_ack_o, misalign_o}, 32'h0);
    chk("rst_addr_be", address_o | {28'h0, byteenable_o}, 32'h0);
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Simultaneous requests: data first, fetch three cycles later.
    begin
      int n;
      readdata_i = 32'h11223344;
      wait_cfg = 0;
      data_req_i = 1'b1; data_we_i = 1'b0; data_size_i = 2'd2;
      data_signed_i = 1'b0; data_addr_i = 32'h4000;
      fetch_req_i = 1'b1; fetch_addr_i = 32'h5000;
      n = cyc;
      rq.push_back('{dat: 1'b1, data: 32'h11223344, mis: 1'b0, cyc: n + 2});
      rq.push_back('{dat: 1'b0, data: 32'h11223344, mis: 1'b0, cyc: n + 5});
      bq.push_back('{we: 1'b0, addr: 32'h4000, be: 4'hF, wd: 32'h0});
      bq.push_back('{we: 1'b0, addr: 32'h5000, be: 4'hF, wd: 32'h0});
      wait_ack(1'b1, "arb_data");
      data_req_i = 1'b0;
      wait_ack(1'b0, "arb_fetch");
      fetch_req_i = 1'b0;
    end

    // Reset in the middle of a stalled read: bus drops, no ack.
    readdata_i = 32'hA5A5A5A5;
    wait_cfg = 100;
    data_req_i = 1'b1; data_we_i = 1'b0; data_size_i = 2'd2; data_addr_i = 32'h6000;
    bq.push_back('{we: 1'b0, addr: 32'h6000, be: 4'hF, wd: 32'h0});
    repeat (3) @(posedge clk);
    #1;
    chk("midbus_read_before", {31'h0, read_o}, 32'h1);
    reset_i = 1'b0;
    data_req_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_read", {30'h0, read_o, write_o}, 32'h0);
    chk("midrst_busy", {31'h0, busy_o}, 32'h0);
    bq.delete();
    @(posedge clk); #1;
    reset_i = 1'b1;
    wait_cfg = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("final_busy", {31'h0, busy_o}, 32'h0);
    chk("resp_queue_empty", rq.size(), 32'h0);
    chk("bus_queue_empty", bq.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
